// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display.
// Holds FSM state encoding, BCD digit limits and 7-segment patterns.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam logic [3:0] DIG_MAX_LO = 4'd9;
   localparam logic [3:0] DIG_MAX_HI = 4'd5;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder (active-low segments).
// Ports: digit_i BCD value in; seg_o {g,f,e,d,c,b,a} out, blank for 10-15.
module seg7_decoder
   import stopwatch_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch with debounced start/clear buttons and 4-digit mux scan.
// Ports: clock/reset_n; clock1Hz/20Hz/500Hz async tick sources;
//        btn_start_n/btn_clear_n raw buttons; running, seg, an, dp outputs.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clock1Hz,
   input  logic       clock20Hz,
   input  logic       clock500Hz,
   input  logic       btn_start_n,
   input  logic       btn_clear_n,
   output logic       running,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int unsigned DS = DEBOUNCE_SAMPLES;

   // Tick sources: bit 0 = 1 Hz, bit 1 = 20 Hz, bit 2 = 500 Hz
   logic [2:0] tsy1_q, tsy2_q, tdly_q, tick_q;
   logic       tick1, tick20, tick500;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tsy1_q <= '0;
         tsy2_q <= '0;
         tdly_q <= '0;
         tick_q <= '0;
      end else begin
         tsy1_q <= {clock500Hz, clock20Hz, clock1Hz};
         tsy2_q <= tsy1_q;
         tdly_q <= tsy2_q;
         tick_q <= tsy2_q & ~tdly_q;
      end
   end

   assign tick1   = tick_q[0];
   assign tick20  = tick_q[1];
   assign tick500 = tick_q[2];

   // Buttons: bit 0 = start, bit 1 = clear; idle level is 1
   logic [1:0]    bsy1_q, bsy2_q;
   logic [DS-1:0] bsh_st_q, bsh_st_d;
   logic [DS-1:0] bsh_cl_q, bsh_cl_d;
   logic [1:0]    stable;
   logic [1:0]    prev_q;
   logic [1:0]    press_q;
   logic          start_p, clear_p;

   always_comb begin
      bsh_st_d = bsh_st_q;
      bsh_cl_d = bsh_cl_q;
      if (tick20) begin
         bsh_st_d = {bsh_st_q[DS-2:0], bsy2_q[0]};
         bsh_cl_d = {bsh_cl_q[DS-2:0], bsy2_q[1]};
      end
   end

   assign stable = {bsh_cl_q == '0, bsh_st_q == '0};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bsy1_q   <= '1;
         bsy2_q   <= '1;
         bsh_st_q <= '1;
         bsh_cl_q <= '1;
         prev_q   <= '0;
         press_q  <= '0;
      end else begin
         bsy1_q   <= {btn_clear_n, btn_start_n};
         bsy2_q   <= bsy1_q;
         bsh_st_q <= bsh_st_d;
         bsh_cl_q <= bsh_cl_d;
         prev_q   <= stable;
         // One pulse on the not-pressed -> pressed transition only
         press_q  <= stable & ~prev_q;
      end
   end

   assign start_p = press_q[0];
   assign clear_p = press_q[1];

   // FSM
   state_e state_q, state_d;
   logic   zero_cnt;

   always_comb begin
      state_d  = state_q;
      zero_cnt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_p) begin
               zero_cnt = 1'b1;
            end else if (start_p) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Clear is ignored here, so start always wins
            if (start_p) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (clear_p) begin
               state_d  = ST_IDLE;
               zero_cnt = 1'b1;
            end else if (start_p) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // BCD count; gated on the current state so a tick landing on a
   // RUN->PAUSE press counts and one landing on a ->RUN press does not
   logic [3:0] s_lo_q, s_hi_q, m_lo_q, m_hi_q;
   logic [3:0] s_lo_d, s_hi_d, m_lo_d, m_hi_d;

   always_comb begin
      s_lo_d = s_lo_q;
      s_hi_d = s_hi_q;
      m_lo_d = m_lo_q;
      m_hi_d = m_hi_q;
      if (zero_cnt) begin
         s_lo_d = '0;
         s_hi_d = '0;
         m_lo_d = '0;
         m_hi_d = '0;
      end else if (tick1 && state_q == ST_RUN) begin
         if (s_lo_q != DIG_MAX_LO) begin
            s_lo_d = s_lo_q + 4'd1;
         end else begin
            s_lo_d = '0;
            if (s_hi_q != DIG_MAX_HI) begin
               s_hi_d = s_hi_q + 4'd1;
            end else begin
               s_hi_d = '0;
               if (m_lo_q != DIG_MAX_LO) begin
                  m_lo_d = m_lo_q + 4'd1;
               end else begin
                  m_lo_d = '0;
                  if (m_hi_q != DIG_MAX_HI) begin
                     m_hi_d = m_hi_q + 4'd1;
                  end else begin
                     m_hi_d = '0;
                  end
               end
            end
         end
      end
   end

   // Scan and display
   logic [1:0] idx_q;
   logic [3:0] sel_dig;
   logic [6:0] seg_dec;
   logic [6:0] seg_q;
   logic [3:0] an_q;
   logic       dp_q;
   logic       run_q;

   always_comb begin
      sel_dig = s_lo_q;
      case (idx_q)
         2'd0: sel_dig = s_lo_q;
         2'd1: sel_dig = s_hi_q;
         2'd2: sel_dig = m_lo_q;
         2'd3: sel_dig = m_hi_q;
         default: sel_dig = s_lo_q;
      endcase
   end

   seg7_decoder u_dec (
      .digit_i (sel_dig),
      .seg_o   (seg_dec)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         s_lo_q  <= '0;
         s_hi_q  <= '0;
         m_lo_q  <= '0;
         m_hi_q  <= '0;
         idx_q   <= '0;
         an_q    <= 4'b1110;
         seg_q   <= SEG_0;
         dp_q    <= 1'b1;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_lo_q  <= s_lo_d;
         s_hi_q  <= s_hi_d;
         m_lo_q  <= m_lo_d;
         m_hi_q  <= m_hi_d;
         if (tick500) idx_q <= idx_q + 2'd1;
         an_q    <= ~(4'b0001 << idx_q);
         seg_q   <= seg_dec;
         dp_q    <= (idx_q != 2'd2);
         run_q   <= (state_q == ST_RUN);
      end
   end

   assign running = run_q;
   assign seg     = seg_q;
   assign an      = an_q;
   assign dp      = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display.
// Directed table, corner-case sequences and random ops vs a time model.
module tb_stopwatch_display;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       clock1Hz = 1'b0;
   logic       clock20Hz = 1'b0;
   logic       clock500Hz = 1'b0;
   logic       btn_start_n = 1'b1;
   logic       btn_clear_n = 1'b1;
   logic       running;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   stopwatch_display #(.DEBOUNCE_SAMPLES(3)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .clock1Hz    (clock1Hz),
      .clock20Hz   (clock20Hz),
      .clock500Hz  (clock500Hz),
      .btn_start_n (btn_start_n),
      .btn_clear_n (btn_clear_n),
      .running     (running),
      .seg         (seg),
      .an          (an),
      .dp          (dp)
   );

   always #10 clock = ~clock;

   localparam logic [6:0] SEGT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;

   localparam int OP_T1    = 0;
   localparam int OP_START = 1;
   localparam int OP_CLR   = 2;
   localparam int OP_BOTH  = 3;

   typedef struct {
      int op;
      int n;
      int run;
      int secs;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Behavioural model: elapsed seconds, mode, scan position
   int m_secs  = 0;
   int m_state = S_IDLE;
   int m_idx   = 0;

   function automatic int digit(int s, int i);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      case (i)
         0: return ss % 10;
         1: return ss / 10;
         2: return mm % 10;
         default: return mm / 10;
      endcase
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse(int which);
      @(negedge clock);
      case (which)
         0: clock1Hz = 1'b1;
         1: clock20Hz = 1'b1;
         default: clock500Hz = 1'b1;
      endcase
      repeat (4) @(posedge clock);
      @(negedge clock);
      clock1Hz = 1'b0;
      clock20Hz = 1'b0;
      clock500Hz = 1'b0;
      repeat (4) @(posedge clock);
      if (which == 2) m_idx = (m_idx + 1) % 4;
   endtask

   task automatic do_t1(int n);
      for (int i = 0; i < n; i++) begin
         pulse(0);
         if (m_state == S_RUN) m_secs = (m_secs + 1) % 3600;
      end
   endtask

   task automatic model_press(bit s, bit c);
      if (s && c) begin
         if (m_state == S_RUN) m_state = S_PAUSE;
         else begin
            m_state = S_IDLE;
            m_secs  = 0;
         end
      end else if (c) begin
         if (m_state != S_RUN) begin
            m_state = S_IDLE;
            m_secs  = 0;
         end
      end else if (s) begin
         if (m_state == S_RUN) m_state = S_PAUSE;
         else m_state = S_RUN;
      end
   endtask

   task automatic release_btns();
      @(negedge clock);
      btn_start_n = 1'b1;
      btn_clear_n = 1'b1;
      repeat (3) @(posedge clock);
      pulse(1);
   endtask

   task automatic do_press(bit s, bit c, int samples);
      @(negedge clock);
      if (s) btn_start_n = 1'b0;
      if (c) btn_clear_n = 1'b0;
      repeat (3) @(posedge clock);
      repeat (samples) pulse(1);
      release_btns();
      if (samples >= 3) model_press(s, c);
   endtask

   // Third start sample lands on the same cycle as a 1 Hz tick
   task automatic coincide_start();
      @(negedge clock);
      btn_start_n = 1'b0;
      repeat (3) @(posedge clock);
      repeat (2) pulse(1);
      @(negedge clock);
      clock20Hz = 1'b1;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      clock1Hz = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);
      clock1Hz = 1'b0;
      clock20Hz = 1'b0;
      repeat (4) @(posedge clock);
      release_btns();
      if (m_state == S_RUN) begin
         m_secs  = (m_secs + 1) % 3600;
         m_state = S_PAUSE;
      end else if (m_state == S_PAUSE) begin
         m_state = S_RUN;
      end
   endtask

   task automatic check_now(string nm);
      @(negedge clock);
      chk({nm, "_run"}, int'(running), int'(m_state == S_RUN));
      chk({nm, "_an"}, int'(an), 15 ^ (1 << m_idx));
      chk({nm, "_seg"}, int'(seg), int'(SEGT[digit(m_secs, m_idx)]));
      chk({nm, "_dp"}, int'(dp), int'(m_idx != 2));
   endtask

   // Walk all four digits against constant expectations
   task automatic check_display(string nm, int exp_run, int exp_secs);
      @(negedge clock);
      chk({nm, "_run"}, int'(running), exp_run);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk({nm, "_an"}, int'(an), 15 ^ (1 << m_idx));
         chk({nm, "_seg"}, int'(seg),
             int'(SEGT[digit(exp_secs, m_idx)]));
         pulse(2);
      end
   endtask

   vec_t tv[$];

   initial begin
      int first_k;
      logic [3:0] scan_an [5];
      logic [6:0] scan_seg [5];
      logic       scan_dp [5];

      tv.push_back('{OP_CLR,   1,   1, 5});
      tv.push_back('{OP_T1,    3,   1, 8});
      tv.push_back('{OP_START, 1,   0, 8});
      tv.push_back('{OP_T1,    2,   0, 8});
      tv.push_back('{OP_START, 1,   1, 8});
      tv.push_back('{OP_T1,    1,   1, 9});
      tv.push_back('{OP_START, 1,   0, 9});
      tv.push_back('{OP_CLR,   1,   0, 0});
      tv.push_back('{OP_T1,    2,   0, 0});
      tv.push_back('{OP_START, 1,   1, 0});
      tv.push_back('{OP_T1,    4,   1, 4});
      tv.push_back('{OP_START, 1,   0, 4});
      tv.push_back('{OP_BOTH,  1,   0, 0});
      tv.push_back('{OP_BOTH,  1,   0, 0});
      tv.push_back('{OP_START, 1,   1, 0});
      tv.push_back('{OP_T1,    3,   1, 3});
      tv.push_back('{OP_BOTH,  1,   0, 3});
      tv.push_back('{OP_START, 1,   1, 3});
      tv.push_back('{OP_T1,    751, 1, 754});

      scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      scan_seg = '{SEGT[4], SEGT[3], SEGT[2], SEGT[1], SEGT[4]};
      scan_dp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_run", int'(running), 0);
      chk("rst_an", int'(an), 4'b1110);
      chk("rst_seg", int'(seg), 7'b1000000);
      chk("rst_dp", int'(dp), 1);
      reset_n = 1'b1;
      repeat (3) @(posedge clock);

      // Two low samples are not a press
      do_press(1'b1, 1'b0, 2);
      @(negedge clock);
      chk("short_press", int'(running), 0);

      // Three low samples: running rises 3 cycles after the sample edge
      @(negedge clock);
      btn_start_n = 1'b0;
      repeat (3) @(posedge clock);
      repeat (2) pulse(1);
      @(negedge clock);
      clock20Hz = 1'b1;
      @(posedge clock);
      first_k = 99;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clock);
         #1;
         if (running && first_k == 99) first_k = k;
      end
      chk("press_latency", first_k, 6);
      @(negedge clock);
      clock20Hz = 1'b0;
      repeat (4) @(posedge clock);
      release_btns();
      m_state = S_RUN;
      do_t1(5);
      check_display("five_sec", 1, 5);

      // Directed table
      foreach (tv[i]) begin
         case (tv[i].op)
            OP_T1:    do_t1(tv[i].n);
            OP_START: do_press(1'b1, 1'b0, 3);
            OP_CLR:   do_press(1'b0, 1'b1, 3);
            default:  do_press(1'b1, 1'b1, 3);
         endcase
         check_display($sformatf("vec%0d", i), tv[i].run, tv[i].secs);
      end

      // Scan at 12:34 starting from the last digit
      while (m_idx != 3) pulse(2);
      for (int k = 0; k < 5; k++) begin
         pulse(2);
         @(negedge clock);
         chk($sformatf("scan%0d_an", k), int'(an), int'(scan_an[k]));
         chk($sformatf("scan%0d_seg", k), int'(seg), int'(scan_seg[k]));
         chk($sformatf("scan%0d_dp", k), int'(dp), int'(scan_dp[k]));
      end

      // Tick coincident with presses
      coincide_start();
      check_display("coin_pause", 0, 755);
      coincide_start();
      check_display("coin_run", 1, 755);

      // Reset in the middle of a run
      do_press(1'b1, 1'b0, 3);
      do_press(1'b0, 1'b1, 3);
      do_press(1'b1, 1'b0, 3);
      do_t1(7);
      check_display("pre_rst", 1, 7);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_run", int'(running), 0);
      chk("mid_rst_an", int'(an), 4'b1110);
      chk("mid_rst_seg", int'(seg), 7'b1000000);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      m_secs  = 0;
      m_state = S_IDLE;
      m_idx   = 0;
      check_display("post_rst", 0, 0);
      do_t1(1);
      check_display("post_rst_t1", 0, 0);
      do_press(1'b1, 1'b0, 3);
      do_t1(1);
      check_display("post_rst_run", 1, 1);

      // Wrap 59:59 -> 00:00
      do_t1(3598);
      check_display("at_5959", 1, 3599);
      do_t1(1);
      check_display("wrapped", 1, 0);

      // Random operations against the model
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 3) do_t1($urandom_range(1, 3));
         else if (r <= 5) do_press(1'b1, 1'b0, 3);
         else if (r == 6) do_press(1'b0, 1'b1, 3);
         else if (r == 7) do_press(1'b1, 1'b1, 3);
         else pulse(2);
         check_now($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter: DEBOUNCE_SAMPLES, 3, consecutive 20 Hz samples a button must hold before it counts as pressed.
REQ-002 Port: clock  in  1  system clock (50 MHz); the single clock domain.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: clock1Hz  in  1  1 Hz square wave from the clock divider; treated as asynchronous data.
REQ-005 Port: clock20Hz  in  1  20 Hz square wave from the clock divider; treated as asynchronous data.
REQ-006 Port: clock500Hz  in  1  500 Hz square wave from the clock divider; treated as asynchronous data.
REQ-007 Port: btn_start_n  in  1  raw start/stop push button, active-low, bouncing.
REQ-008 Port: btn_clear_n  in  1  raw clear push button, active-low, bouncing.
REQ-009 Port: running  out  1  high while the FSM is in RUN.
REQ-010 Port: seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 Port: an  out  4  digit enables, one-cold, active-low, registered; an[0] is the rightmost digit.
REQ-012 Port: dp  out  1  decimal point, active-low, registered.

Function
REQ-013 None of clock1Hz, clock20Hz or clock500Hz SHALL be used as a clock; each passes through a 2-FF synchronizer followed by a rising-edge detector.
REQ-014 Tick latency: an input rising edge captured at edge N SHALL produce tick1, tick20 or tick500 high from edge N+2 to N+3, exactly one cycle wide.
REQ-015 Each button SHALL pass through a 2-FF synchronizer and be sampled into a DEBOUNCE_SAMPLES-bit shift register on each tick20.
REQ-016 A button is stable-pressed when all shift-register samples are 0; the transition from not-pressed to stable-pressed SHALL emit one single-cycle press pulse, and holding the button SHALL emit no further pulses.
REQ-017 The FSM states SHALL be IDLE, RUN and PAUSE.
REQ-018 Start press transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-019 Clear press SHALL send IDLE->IDLE or PAUSE->IDLE and zero all digits, and SHALL be ignored in RUN.
REQ-020 For simultaneous start and clear presses: in IDLE or PAUSE clear wins (->IDLE, digits zeroed); in RUN start wins (->PAUSE).
REQ-021 The count SHALL be four BCD digits: sec_lo 0-9, sec_hi 0-5, min_lo 0-9, min_hi 0-5.
REQ-022 The count SHALL increment by one second on tick1 only when the current state is RUN.
REQ-023 If tick1 coincides with a RUN->PAUSE press, the tick SHALL be counted; if tick1 coincides with an IDLE->RUN or PAUSE->RUN press, it SHALL NOT be counted.
REQ-024 At 59:59, tick1 SHALL wrap the count to 00:00 and the state SHALL remain RUN.
REQ-025 A 2-bit scan index SHALL advance on tick500 and wrap 3->0.
REQ-026 Digit mapping: index 0 = sec_lo, 1 = sec_hi, 2 = min_lo, 3 = min_hi.
REQ-027 an, seg and dp SHALL update one cycle after the scan index or the count changes.
REQ-028 an SHALL be 1 for all digits except an[index], which is 0.
REQ-029 seg SHALL be the decode of the selected digit.
REQ-030 dp SHALL be 0 only while index = 2 (the separator between minutes and seconds).
REQ-031 running SHALL be registered and SHALL equal (state == RUN).

Reset
REQ-032 Assertion of reset_n SHALL asynchronously force: state IDLE, all digits 0, scan index 0, running 0, an 4'b1110, seg 7'b1000000 ('0'), dp 1.
REQ-033 Reset SHALL force all tick synchronizer and edge-detect flops to 0.
REQ-034 Reset SHALL force all button synchronizer and shift-register flops to 1 (released), so deassertion never produces a false press.
REQ-035 Reset asserted mid-RUN SHALL discard the count and any pending press; the first tick after deassertion SHALL be handled normally.

Structure
REQ-036 A shared package stopwatch_pkg SHALL hold the state encoding, the BCD digit limits (9 and 5), and the 7-segment patterns for digits 0-9 plus blank.
REQ-037 The combinational BCD-to-7-segment decode SHALL be a separate sub-module, seg7_decoder, instantiated once and fed by the scan mux.
REQ-038 All other logic (synchronizers, debounce, FSM, BCD counter, scan) SHALL reside in stopwatch_display.

Verification
REQ-039 Scenario, reset mid-RUN: drive reset_n low at count 00:07 -> same cycle running=0, an=1110, seg=1000000; after release, count 00:00 and state IDLE.
REQ-040 Scenario, debounce: btn_start_n low for 2 tick20 samples then released -> no transition; held low for 3 samples -> running=1 three cycles after the third sample; then 5 tick1 pulses -> 00:05.
REQ-041 Scenario, wrap: 3599 tick1 pulses in RUN -> 59:59; next tick1 -> 00:00 with running=1.
REQ-042 Scenario, clear handling: clear press in RUN -> ignored, count unchanged; start press to PAUSE, then clear -> IDLE at 00:00; start and clear pressed together in PAUSE -> IDLE at 00:00.
REQ-043 Scenario, display scan: count 12:34 with 5 tick500 pulses -> an sequence 1110,1101,1011,0111,1110 with seg = '4','3','2','1','4'; dp=0 only while an=1011.
REQ-044 Scenario, tick and press coincident: tick1 in the same cycle as a RUN->PAUSE press -> count +1; tick1 in the same cycle as a PAUSE->RUN press -> count unchanged.
